// File: rtl/uart_tx_engine_if.sv
// Byte handshake between the host register block and the UART transmit engine.
// The master drives data/valid, the engine answers with ready.
interface uart_tx_engine_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: small byte FIFO feeding a start/data/parity/stop framer
// paced by an oversampled baud tick, with CTS gating and a THR-empty interrupt.
module uart_tx_engine #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    baud_tick,
    uart_tx_engine_if.slave         tx,
    input  logic [1:0]              cfg_wls,
    input  logic                    cfg_pen,
    input  logic                    cfg_eps,
    input  logic                    cfg_stb,
    input  logic                    cfg_break,
    input  logic                    cts_en,
    input  logic                    cts_n,
    input  logic                    ien_thre,
    output logic                    txd,
    output logic                    tx_busy,
    output logic                    thre,
    output logic                    temt,
    output logic                    intrpt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(2 * OVERSAMPLE);

    localparam logic [CW-1:0] CntFull   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TickLast1 = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TickLast2 = TW'(2 * OVERSAMPLE - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic          start_ok;
    logic [7:0]    head;

    assign tx.tx_ready = (count_q != CntFull);
    assign push        = tx.tx_valid & tx.tx_ready;
    assign head        = mem_q[rd_ptr_q];
    assign start_ok    = (count_q != '0) & (~cts_en | ~cts_n);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx.tx_data;
        end
    end

    // ---------------------------------------------------------------- framer
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    wls_q, wls_d;
    logic          pen_q, pen_d;
    logic          stb_q, stb_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          intrpt_q;
    logic          load;
    logic          bit_done;
    logic [TW-1:0] tick_last;
    logic [7:0]    head_mask;
    logic          head_par;
    logic          fsm_txd;

    // Parity is resolved when the frame is loaded so eps never needs its own latch.
    assign head_mask = 8'hFF >> (2'd3 - cfg_wls);
    assign head_par  = cfg_eps ? (^(head & head_mask)) : (~^(head & head_mask));

    assign tick_last = (state_q == StStop && stb_q) ? TickLast2 : TickLast1;
    assign bit_done  = baud_tick & (tick_q == tick_last);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        wls_d   = wls_q;
        pen_d   = pen_q;
        stb_d   = stb_q;
        par_d   = par_q;
        load    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    load = 1'b1;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    tick_d  = '0;
                    bit_d   = '0;
                end else if (baud_tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    tick_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
                        state_d = pen_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else if (baud_tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    tick_d  = '0;
                end else if (baud_tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when another byte is ready.
                    if (start_ok) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tick_d  = '0;
                    end
                end else if (baud_tick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase

        if (load) begin
            pop     = 1'b1;
            state_d = StStart;
            tick_d  = '0;
            bit_d   = '0;
            shreg_d = head;
            wls_d   = cfg_wls;
            pen_d   = cfg_pen;
            stb_d   = cfg_stb;
            par_d   = head_par;
        end
    end

    // txd is registered from the next-state view so it changes on the same edge as the FSM.
    always_comb begin
        case (state_d)
            StStart:  fsm_txd = 1'b0;
            StData:   fsm_txd = shreg_d[0];
            StParity: fsm_txd = par_d;
            default:  fsm_txd = 1'b1;
        endcase
        txd_d = fsm_txd & ~cfg_break;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            wls_q    <= '0;
            pen_q    <= 1'b0;
            stb_q    <= 1'b0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            intrpt_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            wls_q    <= wls_d;
            pen_q    <= pen_d;
            stb_q    <= stb_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            intrpt_q <= ien_thre & thre;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = (state_q != StIdle);
    assign thre    = (count_q == '0);
    assign temt    = thre & ~tx_busy;
    assign intrpt  = intrpt_q;

    a_no_pop_empty : assert property (@(posedge clock) disable iff (!reset)
        pop |-> (count_q != '0));
    a_no_push_full : assert property (@(posedge clock) disable iff (!reset)
        push |-> (count_q != CntFull));
    a_count_bound  : assert property (@(posedge clock) disable iff (!reset)
        count_q <= CntFull);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a table of single-frame formats followed by
// hand-written sequences for slow ticks, CTS back-to-back, break and mid-frame reset.
module tb_uart_tx_engine;

    logic       clock;
    logic       reset;
    logic       baud_tick;
    logic [1:0] cfg_wls;
    logic       cfg_pen;
    logic       cfg_eps;
    logic       cfg_stb;
    logic       cfg_break;
    logic       cts_en;
    logic       cts_n;
    logic       ien_thre;
    logic       txd;
    logic       tx_busy;
    logic       thre;
    logic       temt;
    logic       intrpt;

    int         n_cmp = 0;
    int         n_err = 0;
    int         tick_div = 1;
    int         tph = 0;

    uart_tx_engine_if tx_if ();

    uart_tx_engine dut (
        .clock     (clock),
        .reset     (reset),
        .baud_tick (baud_tick),
        .tx        (tx_if),
        .cfg_wls   (cfg_wls),
        .cfg_pen   (cfg_pen),
        .cfg_eps   (cfg_eps),
        .cfg_stb   (cfg_stb),
        .cfg_break (cfg_break),
        .cts_en    (cts_en),
        .cts_n     (cts_n),
        .ien_thre  (ien_thre),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .thre      (thre),
        .temt      (temt),
        .intrpt    (intrpt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        baud_tick = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            tph       = (tph + 1) % tick_div;
            baud_tick = (tph == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [1:0]  wls;
        logic        pen;
        logic        eps;
        logic        stb;
        logic [7:0]  data;
        logic [11:0] bits;   // transmitted bits, first bit in bit 11
        logic [3:0]  nbits;  // 16-clock units in the whole frame
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    initial begin
        int   w;
        logic exp_bit;

        vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 12'b0101_0010_1100, 4'd10}; // 8N1
        vecs[1] = '{2'b10, 1'b1, 1'b1, 1'b1, 8'h41, 12'b0100_0001_0110, 4'd11}; // 7E2
        vecs[2] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'hEA, 12'b0010_1010_0000, 4'd7};  // 5N1
        vecs[3] = '{2'b01, 1'b1, 1'b0, 1'b0, 8'h2B, 12'b0110_1011_1000, 4'd9};  // 6O1
        vecs[4] = '{2'b11, 1'b1, 1'b1, 1'b0, 8'hFF, 12'b0111_1111_1010, 4'd11}; // 8E1
        vecs[5] = '{2'b11, 1'b1, 1'b0, 1'b1, 8'h80, 12'b0000_0000_1011, 4'd12}; // 8O2

        reset           = 1'b0;
        tx_if.tx_data   = 8'h00;
        tx_if.tx_valid  = 1'b0;
        cfg_wls         = 2'b11;
        cfg_pen         = 1'b0;
        cfg_eps         = 1'b0;
        cfg_stb         = 1'b0;
        cfg_break       = 1'b0;
        cts_en          = 1'b0;
        cts_n           = 1'b1;
        ien_thre        = 1'b1;

        repeat (3) step();
        check("rst_txd", txd, 1);
        check("rst_ready", tx_if.tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_thre", thre, 1);
        check("rst_temt", temt, 1);
        check("rst_intrpt", intrpt, 0);
        reset = 1'b1;
        step();
        check("intrpt_after_rst", intrpt, 1);

        // Table of single frames, baud_tick every cycle.
        for (int v = 0; v < 6; v++) begin
            cfg_wls = vecs[v].wls;
            cfg_pen = vecs[v].pen;
            cfg_eps = vecs[v].eps;
            cfg_stb = vecs[v].stb;
            step();
            step();
            check("idle_intrpt", intrpt, 1);
            tx_if.tx_data  = vecs[v].data;
            tx_if.tx_valid = 1'b1;
            step();
            tx_if.tx_valid = 1'b0;
            check("accept_txd_idle", txd, 1);
            check("accept_thre", thre, 0);
            step();
            check("start_latency", txd, 0);
            check("intrpt_drop", intrpt, 0);
            // Flip the configuration mid-frame; the frame must keep its latched format.
            cfg_wls = ~vecs[v].wls;
            cfg_pen = ~vecs[v].pen;
            cfg_eps = ~vecs[v].eps;
            cfg_stb = ~vecs[v].stb;
            repeat (8) step();
            for (int k = 0; k < int'(vecs[v].nbits); k++) begin
                if (k != 0) repeat (16) step();
                check("frame_bit", txd, vecs[v].bits[11-k]);
            end
            repeat (7) step();
            check("frame_last_busy", tx_busy, 1);
            step();
            check("frame_end_busy", tx_busy, 0);
            check("frame_end_temt", temt, 1);
            check("frame_end_txd", txd, 1);
        end

        // 5O1 with baud_tick every third cycle.
        cfg_wls  = 2'b00;
        cfg_pen  = 1'b1;
        cfg_eps  = 1'b0;
        cfg_stb  = 1'b0;
        tick_div = 3;
        step();
        step();
        tx_if.tx_data  = 8'h1F;
        tx_if.tx_valid = 1'b1;
        step();
        tx_if.tx_valid = 1'b0;
        w = 0;
        while (txd !== 1'b0 && w < 10) begin
            step();
            w++;
        end
        check("slow_start_seen", txd, 0);
        repeat (24) step();
        check("slow_start_bit", txd, 0);
        for (int k = 1; k <= 5; k++) begin
            repeat (48) step();
            check("slow_data_bit", txd, 1);
        end
        w = 0;
        while (txd !== 1'b0 && w < 40) begin
            step();
            w++;
        end
        check("slow_parity_seen", txd, 0);
        w = 0;
        while (txd === 1'b0 && w < 60) begin
            step();
            w++;
        end
        check("slow_parity_width", w, 48);
        check("slow_stop_bit", txd, 1);
        w = 0;
        while (tx_busy !== 1'b0 && w < 60) begin
            step();
            w++;
        end
        check("slow_end_busy", tx_busy, 0);
        check("slow_end_temt", temt, 1);
        tick_div = 1;

        // CTS held off: fill the FIFO, then release for back-to-back frames.
        cfg_wls = 2'b11;
        cfg_pen = 1'b0;
        cfg_stb = 1'b0;
        cts_en  = 1'b1;
        cts_n   = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            tx_if.tx_data  = 8'(i + 1);
            tx_if.tx_valid = 1'b1;
            step();
        end
        check("cts_full_ready", tx_if.tx_ready, 0);
        tx_if.tx_data = 8'h05;
        repeat (3) begin
            step();
            check("cts_hold_ready", tx_if.tx_ready, 0);
            check("cts_hold_txd", txd, 1);
        end
        tx_if.tx_valid = 1'b0;
        check("cts_hold_busy", tx_busy, 0);
        cts_n = 1'b0;
        step();
        for (int c = 0; c < 640; c++) begin
            exp_bit = frame_bit(8'(c / 160 + 1), (c % 160) / 16);
            check("cts_b2b_txd", txd, exp_bit);
            if (c == 328) check("cts_thre_mid", thre, 0);
            if (c == 488) check("cts_thre_last", thre, 1);
            step();
        end
        check("cts_end_busy", tx_busy, 0);
        check("cts_end_temt", temt, 1);
        cts_en = 1'b0;
        cts_n  = 1'b1;

        // Break asserted during the data bits of 0xFF.
        step();
        tx_if.tx_data  = 8'hFF;
        tx_if.tx_valid = 1'b1;
        step();
        tx_if.tx_valid = 1'b0;
        step();
        for (int c = 0; c < 160; c++) begin
            exp_bit = (c >= 41 && c <= 60) ? 1'b0 : frame_bit(8'hFF, c / 16);
            check("break_txd", txd, exp_bit);
            cfg_break = (c >= 40 && c < 60);
            step();
        end
        check("break_end_busy", tx_busy, 0);
        check("break_end_txd", txd, 1);

        // Reset during data bit 3 of 0x55 with two more bytes queued.
        step();
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h55;
        step();
        tx_if.tx_data  = 8'h11;
        step();
        tx_if.tx_data  = 8'h22;
        step();
        tx_if.tx_valid = 1'b0;
        repeat (71) step();
        check("pre_rst_txd", txd, 0);
        check("pre_rst_thre", thre, 0);
        reset = 1'b0;
        step();
        check("mid_rst_txd", txd, 1);
        check("mid_rst_thre", thre, 1);
        check("mid_rst_temt", temt, 1);
        check("mid_rst_intrpt", intrpt, 0);
        check("mid_rst_busy", tx_busy, 0);
        reset = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step();
            check("post_rst_txd", txd, 1);
            check("post_rst_busy", tx_busy, 0);
        end
        check("post_rst_intrpt", intrpt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit-side serializer feeding the UART txd line.
- Accepts parallel bytes over a valid/ready handshake into a small FIFO.
- Frames each byte as start / 5-8 data bits / optional parity / 1-2 stop bits, paced by a 16x oversample baud tick.
- Honours cts_n flow control and raises a THR-empty interrupt toward the host register block.

Parameters:
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2.
- OVERSAMPLE, 16, baud_tick pulses per bit period.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- baud_tick  input  1  one-clock-wide enable at OVERSAMPLE x baud rate.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept (count != FIFO_DEPTH).
- cfg_wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- cfg_pen  input  1  parity enable.
- cfg_eps  input  1  1=even parity, 0=odd.
- cfg_stb  input  1  0=one stop bit, 1=two.
- cfg_break  input  1  force txd low.
- cts_en  input  1  enable CTS flow control.
- cts_n  input  1  clear to send, active low.
- ien_thre  input  1  THR-empty interrupt enable.
- txd  output  1  serial output, registered.
- tx_busy  output  1  state != IDLE.
- thre  output  1  FIFO empty.
- temt  output  1  FIFO empty and state == IDLE.
- intrpt  output  1  registered ien_thre & thre.

Behaviour:
- Reset (reset==0 at a clock edge): txd=1, FIFO count=0, state=IDLE, tx_ready=1, tx_busy=0, thre=1, temt=1, intrpt=0. Applies mid-frame: the frame is abandoned, txd=1 from the next cycle, and FIFO contents are discarded.
- FIFO: a write occurs when tx_valid & tx_ready. A pop occurs only on the IDLE->START or STOP->START transition. Simultaneous write and pop keeps count unchanged. A write when full is impossible (tx_ready=0). There is no bypass: a byte written into an empty FIFO is seen one cycle later.
- Start condition: FIFO non-empty & (!cts_en | !cts_n).
- At frame start, latch the FIFO head plus cfg_wls, cfg_pen, cfg_eps and cfg_stb. Config changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on the start condition. txd=0 takes effect from the next cycle; tick_cnt clears.
  - Each START/DATA/PARITY bit lasts exactly OVERSAMPLE baud_ticks; tick_cnt advances only on baud_tick.
  - START -> DATA after OVERSAMPLE ticks.
  - DATA shifts out LSB first, wls+5 bits; bit_cnt counts 0..wls+4.
  - Last data bit -> PARITY if pen, else -> STOP.
  - PARITY bit = ^data[wls+4:0] when eps=1, ~^ of the same when eps=0.
  - STOP drives txd=1 for OVERSAMPLE ticks (stb=0) or 2*OVERSAMPLE ticks (stb=1).
  - STOP end -> START directly if the start condition holds (back-to-back frames, no idle gap), else -> IDLE.
- CTS deasserting mid-frame does not stop the current frame; it is only checked at frame boundaries.
- cfg_break=1: txd=0 next cycle regardless of state. The FSM and FIFO continue normally. Releasing break restores the FSM-driven txd next cycle.
- Latency: byte accepted at edge N -> txd=0 after edge N+1 (idle FIFO, CTS ok).
- intrpt follows thre&ien_thre with one cycle of delay. It deasserts the cycle after the first FIFO write.

Test Plan:
- 8N1, baud_tick=1 every cycle, write 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit for 16 clocks, 160 clocks total. Then temt=1 and tx_busy=0.
- 7E2 (wls=10, pen=1, eps=1, stb=1), write 0x41 -> start 0; data 1,0,0,0,0,0,1; parity 0; stop held 1 for 32 ticks.
- 5O1 with baud_tick every 3rd cycle, write 0x1F -> 5 data ones, odd parity bit 0; each bit lasts 48 clocks.
- cts_en=1, cts_n=1, write 5 bytes 0x01..0x05 -> tx_ready=0 after the 4th, 5th not accepted, txd stays 1. Then drop cts_n -> 0x01..0x04 sent back-to-back with no idle cycles; thre=1 after the 4th pop.
- Assert cfg_break during the DATA state of 0xFF -> txd=0 next cycle. Release before stop -> stop bit = 1; the frame ends on time.
- Assert reset during bit 3 of 0x55 with 2 bytes queued -> next cycle txd=1, thre=1, temt=1, intrpt=0; no further frames are sent.
